axi_output_fifo: RTL

AXI_OUTPUT_FIFO -- requirements
Module: axi_output_fifo

---
 rtl/axi_fifo_pkg.sv | 21 ++
 rtl/axi_out_word_packer.sv | 40 ++++
 rtl/axi_output_fifo.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/axi_fifo_pkg.sv
// Shared constants for the AXI output FIFO: buffer geometry, read FSM encoding
// and the rate-select to words-per-block table.
package axi_fifo_pkg;

    localparam int DEPTH  = 64;
    localparam int AW     = 7;
    localparam int WORD_W = 32;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic logic [5:0] words_per_block(input logic [1:0] sel);
        case (sel)
            2'd0:    return 6'd36;
            2'd1:    return 6'd34;
            2'd2:    return 6'd26;
            default: return 6'd18;
        endcase
    endfunction

endpackage

// File: rtl/axi_out_word_packer.sv
// Collects hash-core output bytes into big-endian 32-bit words; the completed
// word is presented combinationally in the cycle its fourth byte is accepted.
module axi_out_word_packer
    import axi_fifo_pkg::*;
(
    input  logic              wclk,
    input  logic              ARESETn,
    input  logic              flush,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic              word_wr,
    output logic [WORD_W-1:0] word_out
);

    logic [1:0]  pcnt;
    logic [23:0] hold;

    always_ff @(posedge wclk or negedge ARESETn) begin
        if (!ARESETn) begin
            pcnt <= 2'd0;
            hold <= 24'd0;
        end else if (flush) begin
            pcnt <= 2'd0;
            hold <= 24'd0;
        end else if (accept) begin
            pcnt <= pcnt + 2'd1;
            case (pcnt)
                2'd0:    hold[23:16] <= byte_in;
                2'd1:    hold[15:8]  <= byte_in;
                2'd2:    hold[7:0]   <= byte_in;
                default: hold        <= hold;
            endcase
        end
    end

    // The fourth byte bypasses the holding register so the word lands this cycle.
    assign word_wr  = accept && (pcnt == 2'd3) && !flush;
    assign word_out = {hold, byte_in};

endmodule

// File: rtl/axi_output_fifo.sv
// Output buffer between the hash core and an AXI read port: bytes are packed
// into words, stored in a circular memory and drained by AXI read bursts.
module axi_output_fifo #(
    parameter int DEPTH = axi_fifo_pkg::DEPTH,
    parameter int AW    = axi_fifo_pkg::AW
) (
    input  logic          wclk,
    input  logic          ARESETn,
    input  logic [1:0]    sel,
    input  logic          flush,
    input  logic          byte_valid,
    input  logic [7:0]    byte_in,
    output logic          byte_ready,
    input  logic          ARVALID,
    input  logic [7:0]    ARLEN,
    output logic          ARREADY,
    output logic          RVALID,
    output logic [31:0]   RDATA,
    output logic [1:0]    RRESP,
    output logic          RLAST,
    input  logic          RREADY,
    output logic [AW-1:0] level,
    output logic          blk_done
);
    import axi_fifo_pkg::*;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              full;
    logic              empty;
    logic              accept;
    logic              word_wr;
    logic [WORD_W-1:0] word_out;
    logic              rd_fire;
    logic [0:0]        state;
    logic [8:0]        beats;
    logic [8:0]        beat_cnt;
    logic [5:0]        blk_cnt;
    logic [5:0]        blk_target;
    logic [5:0]        cur_target;

    assign full       = (wptr[AW-1] != rptr[AW-1]) && (wptr[AW-2:0] == rptr[AW-2:0]);
    assign empty      = (wptr == rptr);
    assign level      = wptr - rptr;
    assign byte_ready = !full;
    assign accept     = byte_valid && byte_ready;

    assign ARREADY = (state == R_IDLE);
    assign RVALID  = (state == R_DATA) && !empty;
    assign RDATA   = mem[rptr[AW-2:0]];
    assign RLAST   = RVALID && (beat_cnt == beats - 9'd1);
    assign RRESP   = 2'b00;
    assign rd_fire = RVALID && RREADY;

    axi_out_word_packer u_packer (
        .wclk     (wclk),
        .ARESETn  (ARESETn),
        .flush    (flush),
        .accept   (accept),
        .byte_in  (byte_in),
        .word_wr  (word_wr),
        .word_out (word_out)
    );

    always_ff @(posedge wclk) begin
        if (word_wr)
            mem[wptr[AW-2:0]] <= word_out;
    end

    always_ff @(posedge wclk or negedge ARESETn) begin
        if (!ARESETn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (word_wr)
                wptr <= wptr + AW'(1);
            if (rd_fire)
                rptr <= rptr + AW'(1);
        end
    end

    // The rate is sampled only on the first word of a block and held until it ends.
    always_comb begin
        cur_target = blk_target;
        if (blk_cnt == 6'd0)
            cur_target = words_per_block(sel);
    end

    always_ff @(posedge wclk or negedge ARESETn) begin
        if (!ARESETn) begin
            blk_cnt    <= 6'd0;
            blk_target <= 6'd0;
            blk_done   <= 1'b0;
        end else if (flush) begin
            blk_cnt    <= 6'd0;
            blk_target <= 6'd0;
            blk_done   <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            if (word_wr) begin
                blk_target <= cur_target;
                if (blk_cnt + 6'd1 == cur_target) begin
                    blk_cnt  <= 6'd0;
                    blk_done <= 1'b1;
                end else begin
                    blk_cnt <= blk_cnt + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge wclk or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= R_IDLE;
            beats    <= 9'd0;
            beat_cnt <= 9'd0;
        end else if (flush) begin
            state    <= R_IDLE;
            beats    <= 9'd0;
            beat_cnt <= 9'd0;
        end else if (state == R_IDLE) begin
            if (ARVALID) begin
                beats    <= {1'b0, ARLEN} + 9'd1;
                beat_cnt <= 9'd0;
                state    <= R_DATA;
            end
        end else if (rd_fire) begin
            if (RLAST) begin
                beat_cnt <= 9'd0;
                state    <= R_IDLE;
            end else begin
                beat_cnt <= beat_cnt + 9'd1;
            end
        end
    end

endmodule
